// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the request-arbiter FSM states.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/axi_lite_req_arbiter_if.sv
// Link between the request arbiter and axi4_lite_master: launch strobes, latched
// address/data, and the observed R/B channel handshakes used to detect completion.
interface axi_lite_req_arbiter_if #(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  START_READ;
    logic                  START_WRITE;
    logic [ADDRESS-1:0]    address;
    logic [DATA_WIDTH-1:0] W_data;
    logic                  mon_rvalid;
    logic                  mon_rready;
    logic [DATA_WIDTH-1:0] mon_rdata;
    logic [1:0]            mon_rresp;
    logic                  mon_bvalid;
    logic                  mon_bready;
    logic [1:0]            mon_bresp;

    modport master (
        output START_READ, START_WRITE, address, W_data,
        input  mon_rvalid, mon_rready, mon_rdata, mon_rresp,
        input  mon_bvalid, mon_bready, mon_bresp
    );

    modport slave (
        input  START_READ, START_WRITE, address, W_data,
        output mon_rvalid, mon_rready, mon_rdata, mon_rresp,
        output mon_bvalid, mon_bready, mon_bresp
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // One extra bit on sum so ptr+k can be folded back below NUM_REQ for any NUM_REQ.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        sum        = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!any && req[cand]) begin
                any              = 1'b1;
                gnt_idx          = cand;
                gnt_onehot[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/axi_lite_req_arbiter.sv
// Shares one AXI4-Lite master among NUM_REQ requesters: round-robin accept, one-cycle
// START pulse, completion from the observed R/B handshake, one-cycle response strobe.
module axi_lite_req_arbiter
    import axi_lite_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDRESS-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [1:0]                    rsp_resp,
    axi_lite_req_arbiter_if.master        m_if,
    output logic                          busy,
    output logic [IDX_W-1:0]              grant_id
);
    arb_state_t            state;
    logic [IDX_W-1:0]      rr_ptr;
    logic                  lat_write;
    logic [NUM_REQ-1:0]    arb_onehot;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_any;
    logic [NUM_REQ-1:0]    grant_onehot;
    logic                  r_done;
    logic                  b_done;
    logic [ADDRESS-1:0]    addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDRESS +: ADDRESS];
        assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .any        (arb_any)
    );

    // Gated by ARESETN so the accept strobe is silent while reset is held.
    assign req_ready    = (ARESETN && state == IDLE) ? arb_onehot : '0;
    assign busy         = (state != IDLE);
    assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
    assign r_done       = m_if.mon_rvalid && m_if.mon_rready;
    assign b_done       = m_if.mon_bvalid && m_if.mon_bready;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            lat_write        <= 1'b0;
            grant_id         <= '0;
            m_if.address     <= '0;
            m_if.W_data      <= '0;
            m_if.START_READ  <= 1'b0;
            m_if.START_WRITE <= 1'b0;
            rsp_valid        <= '0;
            rsp_rdata        <= '0;
            rsp_resp         <= RESP_OKAY;
        end else begin
            m_if.START_READ  <= 1'b0;
            m_if.START_WRITE <= 1'b0;
            rsp_valid        <= '0;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        grant_id         <= arb_idx;
                        lat_write        <= req_write[arb_idx];
                        m_if.address     <= addr_arr[arb_idx];
                        m_if.W_data      <= wdata_arr[arb_idx];
                        m_if.START_WRITE <= req_write[arb_idx];
                        m_if.START_READ  <= !req_write[arb_idx];
                        state            <= LAUNCH;
                    end
                end
                LAUNCH: state <= WAIT;
                // Only the handshake matching the latched direction ends the transfer.
                WAIT: begin
                    if (lat_write ? b_done : r_done) begin
                        rsp_valid <= grant_onehot;
                        rsp_resp  <= lat_write ? m_if.mon_bresp : m_if.mon_rresp;
                        rsp_rdata <= lat_write ? '0 : m_if.mon_rdata;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Self-checking bench for axi_lite_req_arbiter against a queue-free round-robin model.
module tb_axi_lite_req_arbiter;
    import axi_lite_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          ACLK    = 1'b0;
    logic          ARESETN = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            busy;
    logic [1:0]      grant_id;

    axi_lite_req_arbiter_if #(.ADDRESS(AW), .DATA_WIDTH(DW)) bus ();

    axi_lite_req_arbiter #(.NUM_REQ(N), .ADDRESS(AW), .DATA_WIDTH(DW)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .m_if      (bus),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    logic [3:0]  o_ready, o_rsp_valid, o_rsp_after;
    logic [1:0]  o_gid, o_resp;
    logic [31:0] o_addr, o_wdata, o_rdata;
    bit o_sr, o_sw, o_timeout, o_start_extra, o_ready_busy, o_early_rsp, o_stable;
    bit o_busy_launch, o_busy_resp, o_busy_after, o_busy_drop;
    int o_wait;

    function automatic int model_pick(int ptr, logic [3:0] mask);
        for (int k = 0; k < N; k++) if (mask[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic clear_hs();
        bus.mon_rvalid = 1'b0; bus.mon_rready = 1'b0; bus.mon_rdata = '0; bus.mon_rresp = 2'b00;
        bus.mon_bvalid = 1'b0; bus.mon_bready = 1'b0; bus.mon_bresp = 2'b00;
    endtask

    task automatic drive_hs(input bit is_b, input logic [31:0] d, input logic [1:0] r);
        if (is_b) begin
            bus.mon_bvalid = 1'b1; bus.mon_bready = 1'b1; bus.mon_bresp = r;
        end else begin
            bus.mon_rvalid = 1'b1; bus.mon_rready = 1'b1; bus.mon_rdata = d; bus.mon_rresp = r;
        end
    endtask

    task automatic sample_busy();
        if (bus.START_READ || bus.START_WRITE) o_start_extra = 1;
        if (req_ready != 0) o_ready_busy = 1;
        if (rsp_valid != 0) o_early_rsp = 1;
        if (bus.address !== o_addr || bus.W_data !== o_wdata) o_stable = 0;
        if (!busy) o_busy_drop = 1;
    endtask

    // Runs one transfer as requesters plus slave; records observations only.
    // Entered and left at #1 after a rising edge.
    task automatic do_xfer(input logic [3:0] mask, input bit hold, input int lat,
                           input logic [1:0] sresp, input logic [31:0] srdata, input bit stray);
        o_timeout = 0; o_start_extra = 0; o_ready_busy = 0; o_early_rsp = 0;
        o_stable = 1; o_busy_drop = 0; o_ready = '0; o_wait = 0;
        req_valid = mask;
        for (int n = 0; n < 20; n++) begin
            @(negedge ACLK);
            if (req_ready != 0) begin o_ready = req_ready; o_wait = n; break; end
        end
        if (o_ready == 0) begin
            o_timeout = 1; req_valid = '0;
            @(posedge ACLK); #1;
            return;
        end
        @(posedge ACLK); #1;
        if (!hold) req_valid = '0;
        @(negedge ACLK);
        o_sr = bus.START_READ; o_sw = bus.START_WRITE; o_gid = grant_id;
        o_addr = bus.address; o_wdata = bus.W_data; o_busy_launch = busy;
        if (req_ready != 0) o_ready_busy = 1;
        if (rsp_valid != 0) o_early_rsp = 1;
        @(posedge ACLK); #1;
        for (int i = 0; i < lat; i++) begin
            if (stray && i == 0) drive_hs(!o_sw, 32'hBAD0_BAD0, ~sresp);
            @(negedge ACLK); sample_busy();
            @(posedge ACLK); #1; clear_hs();
        end
        drive_hs(o_sw, srdata, sresp);
        @(negedge ACLK); sample_busy();
        @(posedge ACLK); #1; clear_hs();
        @(negedge ACLK);
        o_rsp_valid = rsp_valid; o_rdata = rsp_rdata; o_resp = rsp_resp; o_busy_resp = busy;
        if (bus.START_READ || bus.START_WRITE) o_start_extra = 1;
        if (req_ready != 0) o_ready_busy = 1;
        if (bus.address !== o_addr || bus.W_data !== o_wdata) o_stable = 0;
        @(posedge ACLK); #1;
        o_rsp_after = rsp_valid; o_busy_after = busy;
    endtask

    task automatic set_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
        req_write[i] = wr; req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        req_valid = '1;
        repeat (3) @(negedge ACLK);
        checks++;
        if ({bus.START_READ, bus.START_WRITE, req_ready, rsp_valid, rsp_rdata, rsp_resp,
             bus.address, bus.W_data, busy, grant_id} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rsp=%b busy=%b gid=%0d addr=%h required all zero",
                     req_ready, rsp_valid, busy, grant_id, bus.address);
        end
        ARESETN = 1'b1; req_valid = '0;
        @(posedge ACLK); #1;
        m_ptr = 0;
    endtask

    task automatic test_write_basic();
        set_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        do_xfer(4'b0001, 1'b0, 2, RESP_OKAY, 32'h7777_7777, 1'b0);
        checks++;
        if (o_timeout || o_ready !== 4'b0001 || o_sw !== 1'b1 || o_sr !== 1'b0 || o_start_extra) begin
            errors++;
            $display("FAIL wr_launch: ready=%b sw=%b sr=%b extra=%b required ready=0001 sw=1 sr=0 single pulse",
                     o_ready, o_sw, o_sr, o_start_extra);
        end
        checks++;
        if (o_addr !== 32'h10 || o_wdata !== 32'hDEAD_BEEF || !o_stable) begin
            errors++;
            $display("FAIL wr_addr_data: addr=%h wdata=%h stable=%b required 00000010 deadbeef stable",
                     o_addr, o_wdata, o_stable);
        end
        checks++;
        if (o_rsp_valid !== 4'b0001 || o_resp !== RESP_OKAY || o_rdata !== 32'h0 || o_rsp_after !== 4'b0 || o_early_rsp) begin
            errors++;
            $display("FAIL wr_rsp: rsp_valid=%b resp=%b rdata=%h after=%b required 0001 00 0 then 0000",
                     o_rsp_valid, o_resp, o_rdata, o_rsp_after);
        end
        m_ptr = 1;
    endtask

    task automatic test_read_basic();
        set_req(2, 1'b0, 32'h0000_0040, 32'h1111_2222);
        do_xfer(4'b0100, 1'b0, 1, RESP_OKAY, 32'h1234_5678, 1'b0);
        checks++;
        if (o_timeout || o_ready !== 4'b0100 || o_sr !== 1'b1 || o_sw !== 1'b0 || o_start_extra || o_addr !== 32'h40) begin
            errors++;
            $display("FAIL rd_launch: ready=%b sr=%b sw=%b extra=%b addr=%h required 0100 sr=1 once addr 40",
                     o_ready, o_sr, o_sw, o_start_extra, o_addr);
        end
        checks++;
        if (o_rsp_valid !== 4'b0100 || o_rdata !== 32'h1234_5678 || o_resp !== RESP_OKAY) begin
            errors++;
            $display("FAIL rd_rsp: rsp_valid=%b rdata=%h resp=%b required 0100 12345678 00",
                     o_rsp_valid, o_rdata, o_resp);
        end
        m_ptr = 3;
    endtask

    task automatic test_stray_handshake();
        set_req(3, 1'b1, 32'h0000_0300, 32'hCAFE_F00D);
        do_xfer(4'b1000, 1'b0, 3, RESP_EXOKAY, 32'h0, 1'b1);
        checks++;
        if (o_timeout || o_early_rsp || o_busy_drop || o_rsp_valid !== 4'b1000) begin
            errors++;
            $display("FAIL stray_r_ignored: early=%b busy_drop=%b rsp_valid=%b required no early completion, 1000",
                     o_early_rsp, o_busy_drop, o_rsp_valid);
        end
        checks++;
        if (o_resp !== RESP_EXOKAY || o_rdata !== 32'h0) begin
            errors++;
            $display("FAIL stray_rsp: resp=%b rdata=%h required 01 00000000", o_resp, o_rdata);
        end
        m_ptr = 0;
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) set_req(i, 1'((i % 2) == 0), 32'h1000 + 32'(i * 4), 32'hA000_0000 + 32'(i));
        for (int k = 0; k < 5; k++) begin
            int eg;
            eg = model_pick(m_ptr, 4'hF);
            do_xfer(4'hF, 1'b1, k % 3, RESP_OKAY, 32'h5000_0000 + 32'(k), 1'b0);
            checks++;
            if (o_timeout || eg != order[k] || o_gid !== 2'(order[k]) || o_ready !== 4'(1 << order[k])) begin
                errors++;
                $display("FAIL rr_order[%0d]: grant=%0d ready=%b required %0d", k, o_gid, o_ready, order[k]);
            end
            checks++;
            if (o_ready_busy || o_start_extra || (k > 0 && o_wait != 0) || o_sw !== req_write[order[k]]) begin
                errors++;
                $display("FAIL rr_handshake[%0d]: ready_while_busy=%b extra_start=%b wait=%0d sw=%b required 0 0 0 %b",
                         k, o_ready_busy, o_start_extra, o_wait, o_sw, req_write[order[k]]);
            end
            m_ptr = (order[k] + 1) % N;
        end
        req_valid = '0;
    endtask

    task automatic test_slverr();
        set_req(1, 1'b0, 32'h0000_0104, 32'h0);
        do_xfer(4'b0010, 1'b0, 2, RESP_SLVERR, 32'hFEED_0001, 1'b0);
        checks++;
        if (o_timeout || o_rsp_valid !== 4'b0010 || o_resp !== RESP_SLVERR || o_rdata !== 32'hFEED_0001) begin
            errors++;
            $display("FAIL slverr: rsp_valid=%b resp=%b rdata=%h required 0010 10 feed0001",
                     o_rsp_valid, o_resp, o_rdata);
        end
        m_ptr = 2;
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic [3:0] mask;
            logic [1:0] rr;
            logic [31:0] rd;
            int lat, eg;
            bit st, ewr;
            for (int i = 0; i < N; i++) set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
            mask = 4'($urandom_range(1, 15));
            lat  = $urandom_range(0, 3);
            st   = (lat > 0) && ($urandom_range(0, 1) == 1);
            rr   = 2'($urandom_range(0, 3));
            rd   = $urandom;
            eg   = model_pick(m_ptr, mask);
            ewr  = req_write[eg];
            do_xfer(mask, 1'b0, lat, rr, rd, st);
            checks++;
            if (o_timeout || o_ready !== 4'(1 << eg) || o_gid !== 2'(eg)) begin
                errors++;
                $display("FAIL rnd_grant[%0d]: mask=%b ready=%b gid=%0d required grant %0d", it, mask, o_ready, o_gid, eg);
            end
            checks++;
            if (o_sw !== ewr || o_sr !== !ewr || o_addr !== req_addr[eg*AW +: AW] || o_wdata !== req_wdata[eg*DW +: DW]) begin
                errors++;
                $display("FAIL rnd_launch[%0d]: sw=%b sr=%b addr=%h wdata=%h required sw=%b addr=%h wdata=%h",
                         it, o_sw, o_sr, o_addr, o_wdata, ewr, req_addr[eg*AW +: AW], req_wdata[eg*DW +: DW]);
            end
            checks++;
            if (!o_stable || o_start_extra || o_ready_busy || o_early_rsp || o_busy_drop ||
                !o_busy_launch || !o_busy_resp || o_busy_after || o_rsp_after !== 4'b0) begin
                errors++;
                $display("FAIL rnd_timing[%0d]: stable=%b extra=%b rdy_busy=%b early=%b busy=%b%b%b after=%b required 1 0 0 0 110 0000",
                         it, o_stable, o_start_extra, o_ready_busy, o_early_rsp,
                         o_busy_launch, o_busy_resp, o_busy_after, o_rsp_after);
            end
            checks++;
            if (o_rsp_valid !== 4'(1 << eg) || o_resp !== rr || o_rdata !== (ewr ? 32'h0 : rd)) begin
                errors++;
                $display("FAIL rnd_rsp[%0d]: rsp_valid=%b resp=%b rdata=%h required %b %b %h",
                         it, o_rsp_valid, o_resp, o_rdata, 4'(1 << eg), rr, ewr ? 32'h0 : rd);
            end
            m_ptr = (eg + 1) % N;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        set_req(1, 1'b0, 32'h0000_0110, 32'h0);
        do_xfer(4'b0010, 1'b0, 0, RESP_OKAY, 32'h0000_0001, 1'b0);
        m_ptr = 2;
        set_req(2, 1'b1, 32'h0000_0200, 32'h5555_AAAA);
        req_valid = 4'b0100;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge ACLK);
            if (req_ready != 0) begin ok = 1; break; end
        end
        @(posedge ACLK); #1; req_valid = '0;
        @(posedge ACLK); #1;
        @(negedge ACLK); #2;
        ARESETN = 1'b0;
        #1;
        checks++;
        if (!ok || {bus.START_READ, bus.START_WRITE, req_ready, rsp_valid, rsp_rdata, rsp_resp,
                    bus.address, bus.W_data, busy, grant_id} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: accepted=%b busy=%b addr=%h wdata=%h gid=%0d required all zero",
                     ok, busy, bus.address, bus.W_data, grant_id);
        end
        req_valid = 4'hF;
        drive_hs(1'b1, 32'h0, RESP_OKAY);
        #1;
        checks++;
        if (req_ready !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ready: ready=%b busy=%b required 0000 0", req_ready, busy);
        end
        @(negedge ACLK);
        clear_hs(); req_valid = '0; ARESETN = 1'b1;
        m_ptr = 0;
        ok = 1;
        repeat (3) begin
            @(negedge ACLK);
            if (rsp_valid != 0 || busy) ok = 0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_mid_silent: rsp_valid=%b busy=%b required no response after release", rsp_valid, busy);
        end
        @(posedge ACLK); #1;
        set_req(3, 1'b0, 32'h0000_0330, 32'h0);
        do_xfer(4'b1010, 1'b0, 1, RESP_OKAY, 32'h0000_1111, 1'b0);
        checks++;
        if (o_timeout || o_gid !== 2'(model_pick(m_ptr, 4'b1010))) begin
            errors++;
            $display("FAIL reset_ptr: grant=%0d required %0d", o_gid, model_pick(m_ptr, 4'b1010));
        end
        m_ptr = 2;
        do_xfer(4'b1000, 1'b0, 1, RESP_DECERR, 32'h3333_0003, 1'b0);
        checks++;
        if (o_timeout || o_gid !== 2'd3 || o_rsp_valid !== 4'b1000 || o_rdata !== 32'h3333_0003 || o_resp !== RESP_DECERR) begin
            errors++;
            $display("FAIL reset_req3: gid=%0d rsp_valid=%b rdata=%h resp=%b required 3 1000 33330003 11",
                     o_gid, o_rsp_valid, o_rdata, o_resp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear_hs();
        test_reset();
        test_write_basic();
        test_read_basic();
        test_stray_handshake();
        test_round_robin();
        test_slverr();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_lite_req_arbiter.md
# axi_lite_req_arbiter

Round-robin arbiter and sequencer that shares one AXI4-Lite master among `NUM_REQ` local requesters. It accepts one read or write request at a time and launches it on the master with a single-cycle `START_READ`/`START_WRITE` pulse. While the master runs, it holds `address`/`W_data` stable and watches the AXI read-data and write-response handshakes to detect completion. It returns read data and response to the granted requester. It sits directly in front of `axi4_lite_master`.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `ADDRESS`, 32: address width.
- `DATA_WIDTH`, 32: data width.

Ports:
- `ACLK`, in, 1: clock.
- `ARESETN`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, NUM_REQ: request pending, one bit per requester.
- `req_write`, in, NUM_REQ: 1 = write, 0 = read, per requester.
- `req_addr`, in, NUM_REQ*ADDRESS: packed addresses; requester i at slice [i*ADDRESS +: ADDRESS].
- `req_wdata`, in, NUM_REQ*DATA_WIDTH: packed write data.
- `req_ready`, out, NUM_REQ: one-hot accept strobe.
- `rsp_valid`, out, NUM_REQ: one-hot completion strobe.
- `rsp_rdata`, out, DATA_WIDTH: read data (0 for writes).
- `rsp_resp`, out, 2: RRESP or BRESP of the completed transfer.
- `START_READ`, out, 1: launch read on master.
- `START_WRITE`, out, 1: launch write on master.
- `address`, out, ADDRESS: address to master.
- `W_data`, out, DATA_WIDTH: write data to master.
- `mon_rvalid`, in, 1: observed M_RVALID.
- `mon_rready`, in, 1: observed M_RREADY.
- `mon_rdata`, in, DATA_WIDTH: observed M_RDATA.
- `mon_rresp`, in, 2: observed M_RRESP.
- `mon_bvalid`, in, 1: observed M_BVALID.
- `mon_bready`, in, 1: observed M_BREADY.
- `mon_bresp`, in, 2: observed M_BRESP.
- `busy`, out, 1: high whenever state != IDLE.
- `grant_id`, out, $clog2(NUM_REQ): index of current/last granted requester.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - Round-robin pick among `req_valid`, starting at `rr_ptr`.
  - If any request is valid, drive `req_ready[g]=1` combinationally.
  - At the clock edge, latch addr, wdata, write flag and g into registers, then go to LAUNCH.
  - The requester must hold its fields stable while `req_valid` is high.
- LAUNCH:
  - Exactly one cycle: `START_WRITE` (if write) or `START_READ` (if read) is 1.
  - Go to WAIT.
- WAIT:
  - Read: on `mon_rvalid && mon_rready`, capture `mon_rdata`/`mon_rresp`, go to RESP.
  - Write: on `mon_bvalid && mon_bready`, capture `mon_bresp`, set rdata to 0, go to RESP.
  - The handshake of the opposite type is ignored.
  - No timeout: WAIT holds indefinitely.
- RESP:
  - `rsp_valid[g]=1` for one cycle; `rsp_rdata`/`rsp_resp` hold the captured values.
  - `rr_ptr <= (g+1) mod NUM_REQ`, then IDLE.
- `address`/`W_data` are registered and hold the latched request values from LAUNCH through RESP.
- Outputs are not cleared on return to IDLE; `rsp_rdata`, `rsp_resp`, `address`, `W_data` and `grant_id` change only on the next capture.
- `START_*`, `rsp_valid`, `address`, `W_data` are registered outputs.

## Timing
- Reset (async assert, sync-to-ACLK deassert handled upstream):
  - State returns to IDLE and `rr_ptr` to 0.
  - All outputs 0: `START_*`, `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_resp`, `address`, `W_data`, `busy`, `grant_id`.
- Reset mid-transfer (LAUNCH/WAIT/RESP) abandons the transfer silently; no `rsp_valid` is issued.
- Accept at edge T. `START_*` is high in cycle T+1 only; the master registers it and leaves its IDLE at T+3.
- Completion handshake in cycle C gives `rsp_valid` in cycle C+1.
- `busy` rises the cycle after acceptance and falls the cycle after RESP.
- Minimum spacing between two acceptances: 4 cycles plus the slave latency.
- A new request is never accepted while `busy`, so `START_*` is never re-pulsed during an active transfer.
- Arbitration boundaries:
  - A single requester still waits for its turn only if another request is valid.
  - `rr_ptr` wraps from NUM_REQ-1 to 0.
  - A requester that drops `req_valid` before grant loses nothing; no state is kept for it.
- Simultaneous handshakes: if `mon_r*` and `mon_b*` handshakes occur in the same WAIT cycle, only the one matching the latched type counts.

## Structure
- Shared package `axi_lite_pkg`:
  - resp codes `RESP_OKAY=2'b00`, `RESP_EXOKAY=2'b01`, `RESP_SLVERR=2'b10`, `RESP_DECERR=2'b11`.
  - `arb_state_t` enum {IDLE, LAUNCH, WAIT, RESP}.
- One sub-module, `rr_arbiter` (params NUM_REQ):
  - inputs `req`, `ptr`.
  - outputs `gnt_onehot`, `gnt_idx`, `any`.
  - purely combinational.
- Pointer and FSM stay in the parent.

## Test plan
- Req0 write addr 0x0000_0010 data 0xDEAD_BEEF, slave BRESP=OKAY after 2 cycles:
  - `START_WRITE` pulses 1 cycle.
  - `address`/`W_data` stable until RESP.
  - `rsp_valid[0]` 1 cycle; `rsp_resp=00`, `rsp_rdata=0`.
- Req2 read addr 0x40, slave RDATA=0x1234_5678 RRESP=OKAY:
  - `START_READ` pulses once.
  - `rsp_valid[2]` with `rsp_rdata=0x1234_5678`.
- All four `req_valid` held high, mixed read/write:
  - grant order 0,1,2,3,0.
  - `rr_ptr` wraps.
  - exactly one `req_ready` per transfer, never while `busy`.
- Req1 read returns RRESP=SLVERR: `rsp_resp=2'b10` on `rsp_valid[1]`.
- Write pending in WAIT while a stray `mon_rvalid && mon_rready` occurs: ignored; completion only on the B handshake.
- `ARESETN` asserted in WAIT:
  - all outputs 0 immediately (async).
  - after release, a new req3 is accepted normally and `rr_ptr` restarts at 0.
